// File: rtl/seven_segment_pkg.sv
// -----------------------------------------------------------------------------
// seven_segment_pkg
// Shared definitions for the seven-segment scan driver:
//   - active-low segment patterns {g,f,e,d,c,b,a} for digits 0..9, blank, dash
//   - default number of BCD digits / anodes
//   - calc_ticks(): per-digit dwell length in clock cycles
// -----------------------------------------------------------------------------
package seven_segment_pkg;

  localparam int DECIMAL_DIGITS_DEFAULT = 4;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  // Cycles each digit stays lit; integer division, caller must keep it >= 2.
  function automatic int calc_ticks(input int clk_freq_hz, input int digit_hz);
    return clk_freq_hz / digit_hz;
  endfunction

endpackage

// File: rtl/bcd_to_seven_segment.sv
// -----------------------------------------------------------------------------
// bcd_to_seven_segment
// Purely combinational BCD nibble to active-low seven-segment decoder.
// Non-decimal nibbles (A..F) show a dash.
// Ports:
//   bcd      in  4  BCD nibble
//   segment  out 7  active-low {g,f,e,d,c,b,a}
// -----------------------------------------------------------------------------
module bcd_to_seven_segment
  import seven_segment_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] segment
);

  // Nibble-to-pattern lookup.
  always_comb begin
    segment = SEG_DASH;
    case (bcd)
      4'd0:    segment = SEG_0;
      4'd1:    segment = SEG_1;
      4'd2:    segment = SEG_2;
      4'd3:    segment = SEG_3;
      4'd4:    segment = SEG_4;
      4'd5:    segment = SEG_5;
      4'd6:    segment = SEG_6;
      4'd7:    segment = SEG_7;
      4'd8:    segment = SEG_8;
      4'd9:    segment = SEG_9;
      default: segment = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seven_segment_scan_driver.sv
// -----------------------------------------------------------------------------
// seven_segment_scan_driver
// Time-multiplexed driver for a common-anode multi-digit seven-segment display.
// One digit is lit at a time for TICKS = CLK_FREQ_HZ/DIGIT_HZ cycles. The BCD
// word and PM flag are snapshotted whenever the scan returns to digit 0, so a
// frame never mixes two input words. PM is shown on digit 0's decimal point.
//
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zero digits
// (digit 0 is never blanked).
//
// Ports:
//   i_Clk           in   1                 system clock
//   i_Rst_n         in   1                 async active-low reset
//   i_Display_Time  in   4*DECIMAL_DIGITS  BCD word, nibble [3:0] = digit 0
//   i_Display_PM    in   1                 PM flag
//   o_Anode         out  DECIMAL_DIGITS    active-low digit enables
//   o_Segment       out  7                 active-low {g,f,e,d,c,b,a}
//   o_DP            out  1                 active-low decimal point
//   o_Frame_Start   out  1                 pulse when digit 0 shows a new snapshot
// -----------------------------------------------------------------------------
module seven_segment_scan_driver
  import seven_segment_pkg::*;
#(
  parameter int CLK_FREQ_HZ    = 100_000_000,
  parameter int DIGIT_HZ       = 1000,
  parameter int DECIMAL_DIGITS = DECIMAL_DIGITS_DEFAULT
) (
  input  logic                        i_Clk,
  input  logic                        i_Rst_n,
  input  logic [4*DECIMAL_DIGITS-1:0] i_Display_Time,
  input  logic                        i_Display_PM,
  output logic [DECIMAL_DIGITS-1:0]   o_Anode,
  output logic [6:0]                  o_Segment,
  output logic                        o_DP,
  output logic                        o_Frame_Start
);

  localparam int TICKS = calc_ticks(CLK_FREQ_HZ, DIGIT_HZ);
  localparam int CNT_W = $clog2(TICKS);
  localparam int IDX_W = (DECIMAL_DIGITS > 1) ? $clog2(DECIMAL_DIGITS) : 1;
  localparam int DW    = 4 * DECIMAL_DIGITS;

  logic [CNT_W-1:0]          cnt_r;
  logic [IDX_W-1:0]          idx_r;
  logic                      started_r;
  logic [DW-1:0]             snap_time_r;
  logic                      snap_pm_r;
  logic [DECIMAL_DIGITS-1:0] anode_r;
  logic [6:0]                segment_r;
  logic                      dp_r;
  logic                      frame_start_r;

  logic                      tick_s;
  logic [IDX_W-1:0]          idx_nxt_s;
  logic                      frame_load_s;
  logic [DW-1:0]             time_sel_s;
  logic                      pm_sel_s;
  logic [3:0]                nibble_s;
  logic [DECIMAL_DIGITS-1:0] anode_nxt_s;
  logic [6:0]                dec_seg_s;
  logic [6:0]                seg_nxt_s;
  logic                      blank_s;

  // Tick detection, next digit index and source word for the digit about to be lit.
  always_comb begin
    tick_s = (cnt_r == CNT_W'(TICKS - 1));
    // The very first tick after reset lands on digit 0 instead of advancing.
    if (!started_r) begin
      idx_nxt_s = '0;
    end else if (idx_r == IDX_W'(DECIMAL_DIGITS - 1)) begin
      idx_nxt_s = '0;
    end else begin
      idx_nxt_s = idx_r + IDX_W'(1);
    end
    frame_load_s = tick_s && (idx_nxt_s == '0);
    // On a frame load the output register must see the word being captured,
    // not the stale snapshot, so digit 0 already belongs to the new frame.
    if (frame_load_s) begin
      time_sel_s = i_Display_Time;
      pm_sel_s   = i_Display_PM;
    end else begin
      time_sel_s = snap_time_r;
      pm_sel_s   = snap_pm_r;
    end
    nibble_s    = time_sel_s[4*idx_nxt_s +: 4];
    anode_nxt_s = ~(DECIMAL_DIGITS'(1) << idx_nxt_s);
  end

  bcd_to_seven_segment u_decode (
    .bcd     (nibble_s),
    .segment (dec_seg_s)
  );

`ifdef LEADING_ZERO_BLANK_EN
  logic [DECIMAL_DIGITS-1:0] lz_s;
  logic                      zero_run_s;

  // Mark each digit whose nibble and every more-significant nibble are zero.
  always_comb begin
    lz_s       = '0;
    zero_run_s = 1'b1;
    for (int k = DECIMAL_DIGITS - 1; k > 0; k--) begin
      zero_run_s = zero_run_s && (time_sel_s[4*k +: 4] == 4'h0);
      lz_s[k]    = zero_run_s;
    end
  end

  assign blank_s = lz_s[idx_nxt_s];
`else
  assign blank_s = 1'b0;
`endif

  assign seg_nxt_s = blank_s ? SEG_BLANK : dec_seg_s;

  // Prescaler: 0..TICKS-1, wraps on the tick.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      cnt_r <= '0;
    end else if (tick_s) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  // Digit index, started flag and per-frame snapshot.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      idx_r       <= '0;
      started_r   <= 1'b0;
      snap_time_r <= '0;
      snap_pm_r   <= 1'b0;
    end else if (tick_s) begin
      idx_r     <= idx_nxt_s;
      started_r <= 1'b1;
      if (frame_load_s) begin
        snap_time_r <= i_Display_Time;
        snap_pm_r   <= i_Display_PM;
      end
    end
  end

  // Registered display outputs; dark until the first tick.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      anode_r       <= '1;
      segment_r     <= SEG_BLANK;
      dp_r          <= 1'b1;
      frame_start_r <= 1'b0;
    end else begin
      frame_start_r <= frame_load_s;
      if (tick_s) begin
        anode_r   <= anode_nxt_s;
        segment_r <= seg_nxt_s;
        dp_r      <= ~(pm_sel_s && (idx_nxt_s == '0));
      end
    end
  end

  assign o_Anode       = anode_r;
  assign o_Segment     = segment_r;
  assign o_DP          = dp_r;
  assign o_Frame_Start = frame_start_r;

endmodule

// File: tb/tb_seven_segment_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seven_segment_scan_driver
// Self-checking bench: TICKS=4, 4 digits. A cycle-count reference model derives
// the expected display from the number of clock edges since reset release and
// the input word seen at each frame boundary; it is compared on every negedge.
// Directed literal checks pin the model, then randomized inputs and resets run.
// -----------------------------------------------------------------------------
module tb_seven_segment_scan_driver;

  localparam int TICKS  = 4;
  localparam int DIGITS = 4;
  localparam int FRAME  = TICKS * DIGITS;
`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  localparam logic [6:0] DEC_TAB [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
    7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] disp_time;
  logic        disp_pm;
  logic [3:0]  anode;
  logic [6:0]  segment;
  logic        dp;
  logic        frame_start;

  int n_err    = 0;
  int n_checks = 0;
  bit chk_en   = 1'b0;

  // model state
  int          e = 0;
  logic [15:0] m_time;
  logic        m_pm;

  seven_segment_scan_driver #(
    .CLK_FREQ_HZ    (40),
    .DIGIT_HZ       (10),
    .DECIMAL_DIGITS (4)
  ) dut (
    .i_Clk          (clk),
    .i_Rst_n        (rst_n),
    .i_Display_Time (disp_time),
    .i_Display_PM   (disp_pm),
    .o_Anode        (anode),
    .o_Segment      (segment),
    .o_DP           (dp),
    .o_Frame_Start  (frame_start)
  );

  always #5 clk = ~clk;

  // Edge count since reset release; the word present at each frame edge is the snapshot.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e      <= 0;
      m_time <= 16'h0000;
      m_pm   <= 1'b0;
    end else begin
      e <= e + 1;
      if ((e + 1) >= TICKS && ((e + 1 - TICKS) % FRAME) == 0) begin
        m_time <= disp_time;
        m_pm   <= disp_pm;
      end
    end
  end

  // Expected {frame_start, dp, anode, segment} after edge ev.
  function automatic logic [12:0] model_out(input int ev, input logic rst_ok,
                                            input logic [15:0] st, input logic sp);
    int         d;
    logic [3:0] an;
    logic [6:0] sg;
    logic       dpe;
    logic       fs;
    if (!rst_ok || ev < TICKS) return {1'b0, 1'b1, 4'hF, 7'h7F};
    d   = ((ev - TICKS) / TICKS) % DIGITS;
    an  = ~(4'b0001 << d);
    sg  = DEC_TAB[(st >> (4 * d)) & 16'h000F];
    if (LZ && d != 0 && (st >> (4 * d)) == 16'h0000) sg = 7'h7F;
    dpe = !(d == 0 && sp);
    fs  = (((ev - TICKS) % FRAME) == 0);
    return {fs, dpe, an, sg};
  endfunction

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [12:0] exp_v;
      exp_v = model_out(e, rst_n, m_time, m_pm);
      n_checks++;
      if ({frame_start, dp, anode, segment} !== exp_v) begin
        n_err++;
        $display("FAIL scan e=%0d: got fs=%b dp=%b an=%b seg=%b, want fs=%b dp=%b an=%b seg=%b",
                 e, frame_start, dp, anode, segment, exp_v[12], exp_v[11], exp_v[10:7], exp_v[6:0]);
      end
    end
  end

  task automatic lit(input string name, input logic [3:0] an, input logic [6:0] sg,
                     input logic dpe, input logic fs);
    n_checks++;
    if ({frame_start, dp, anode, segment} !== {fs, dpe, an, sg}) begin
      n_err++;
      $display("FAIL %s: got fs=%b dp=%b an=%b seg=%b, want fs=%b dp=%b an=%b seg=%b",
               name, frame_start, dp, anode, segment, fs, dpe, an, sg);
    end
  endtask

  task automatic goto_e(input int target);
    bit found;
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(negedge clk);
      if (e == target) found = 1'b1;
    end
    if (!found) begin
      n_checks++;
      n_err++;
      $display("FAIL goto_e: model edge count %0d never reached %0d", e, target);
    end
  endtask

  function automatic logic [15:0] rand_word();
    logic [15:0] w;
    for (int i = 0; i < 4; i++) begin
      w[4*i +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
    end
    return w;
  endfunction

  initial begin
    rst_n     = 1'b1;
    disp_time = 16'h1228;
    disp_pm   = 1'b0;
    #1 rst_n  = 1'b0;
    #2 chk_en = 1'b1;
    repeat (3) @(negedge clk);
    lit("reset_dark", 4'hF, 7'h7F, 1'b1, 1'b0);
    #1 rst_n = 1'b1;

    goto_e(3);  lit("dark_before_tick", 4'hF, 7'h7F, 1'b1, 1'b0);
    goto_e(4);  lit("f0_d0", 4'b1110, 7'b0000000, 1'b1, 1'b1);
    goto_e(5);  lit("f0_d0_hold", 4'b1110, 7'b0000000, 1'b1, 1'b0);
    goto_e(8);  lit("f0_d1", 4'b1101, 7'b0100100, 1'b1, 1'b0);
    goto_e(12); lit("f0_d2", 4'b1011, 7'b0100100, 1'b1, 1'b0);
    goto_e(16); lit("f0_d3", 4'b0111, 7'b1111001, 1'b1, 1'b0);
    goto_e(20); lit("f1_d0", 4'b1110, 7'b0000000, 1'b1, 1'b1);
    #1 disp_pm = 1'b1;

    goto_e(35); lit("pm_not_yet", 4'b0111, 7'b1111001, 1'b1, 1'b0);
    goto_e(36); lit("pm_d0", 4'b1110, 7'b0000000, 1'b0, 1'b1);
    goto_e(40); lit("pm_d1", 4'b1101, 7'b0100100, 1'b1, 1'b0);
    goto_e(41);
    #1 begin disp_time = 16'h0516; disp_pm = 1'b0; end

    goto_e(44); lit("torn_d2", 4'b1011, 7'b0100100, 1'b1, 1'b0);
    goto_e(48); lit("torn_d3", 4'b0111, 7'b1111001, 1'b1, 1'b0);
    goto_e(52); lit("new_d0", 4'b1110, 7'b0000010, 1'b1, 1'b1);
    goto_e(56); lit("new_d1", 4'b1101, 7'b1111001, 1'b1, 1'b0);
    goto_e(60); lit("new_d2", 4'b1011, 7'b0010010, 1'b1, 1'b0);
    goto_e(64); lit("new_d3", 4'b0111, LZ ? 7'h7F : 7'b1000000, 1'b1, 1'b0);

    // change coincident with the load tick is captured
    goto_e(67);
    #1 disp_time = 16'h00A3;
    goto_e(68); lit("coincident_d0", 4'b1110, 7'b0110000, 1'b1, 1'b1);
    #1 disp_time = 16'h0000;
    goto_e(72); lit("dash_d1", 4'b1101, 7'b0111111, 1'b1, 1'b0);
    goto_e(76); lit("a3_d2", 4'b1011, LZ ? 7'h7F : 7'b1000000, 1'b1, 1'b0);
    goto_e(84); lit("zero_d0", 4'b1110, 7'b1000000, 1'b1, 1'b1);
    goto_e(88); lit("zero_d1", 4'b1101, LZ ? 7'h7F : 7'b1000000, 1'b1, 1'b0);

    // mid-frame reset during digit 2 blanks at once
    goto_e(92);
    #1 rst_n = 1'b0;
    #1 lit("midframe_reset", 4'hF, 7'h7F, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    #1 begin rst_n = 1'b1; disp_time = 16'h1228; disp_pm = 1'b1; end

    // randomized words, PM and occasional one-cycle resets
    for (int i = 0; i < 1500; i++) begin
      int r;
      @(negedge clk);
      #1;
      r = $urandom_range(0, 99);
      if (!rst_n) begin
        rst_n = 1'b1;
      end else if (r < 8) begin
        disp_time = rand_word();
        disp_pm   = 1'($urandom_range(0, 1));
      end else if (r == 8) begin
        rst_n = 1'b0;
      end
    end
    @(negedge clk);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/seven_segment_scan_driver.md
# seven_segment_scan_driver

Time-multiplexed driver for the 4-digit common-anode seven-segment display. It sits directly downstream of the display-select/PM mux and consumes its BCD display word and PM flag. It scans one digit at a time at a fixed refresh rate and decodes BCD to active-low segments, with the PM indicator on the decimal point. Input is snapshotted once per frame so a mid-frame change never produces a torn display.

## Interface
- CLK_FREQ_HZ, 100_000_000, input clock frequency.
- DIGIT_HZ, 1000, per-digit dwell rate. TICKS = CLK_FREQ_HZ/DIGIT_HZ, integer division, must be ≥ 2.
- DECIMAL_DIGITS, 4, number of BCD digits and anodes.
- i_Clk  in  1  system clock, 100 MHz.
- i_Rst_n  in  1  reset, asynchronous, active-low.
- i_Display_Time  in  4*DECIMAL_DIGITS  BCD word. Nibble [3:0] is digit 0, the rightmost digit.
- i_Display_PM  in  1  PM flag.
- o_Anode  out  DECIMAL_DIGITS  active-low digit enables, one-hot-low when active.
- o_Segment  out  7  active-low {g,f,e,d,c,b,a}.
- o_DP  out  1  active-low decimal point.
- o_Frame_Start  out  1  one-cycle pulse when digit 0 is driven with a newly loaded snapshot.

## Operation
- The prescaler counts 0..TICKS-1 and wraps. A tick is the cycle where the count equals TICKS-1.
- On each tick:
  - The digit index advances and wraps from DECIMAL_DIGITS-1 to 0.
  - The first tick after reset selects index 0.
- Whenever the index becomes 0:
  - The snapshot register loads i_Display_Time and i_Display_PM.
  - o_Frame_Start pulses.
- The digits of a frame always come from one snapshot.
- Decode (active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000. Nibbles A–F decode to a dash, 0111111.
- o_DP = 0 only while digit 0 is active and the snapshot PM = 1. Otherwise o_DP = 1.
- Exactly one anode is low at any time after the first tick. There are no blank gaps between digits.

## Timing
- Reset values, applied immediately on i_Rst_n low with no clock edge needed:
  - o_Anode all 1, o_Segment 7'h7F, o_DP 1, o_Frame_Start 0.
  - Prescaler 0, index 0, snapshot 0.
  - A "started" flag is cleared.
- After reset release, outputs stay dark until the first tick, at cycle TICKS-1.
- All outputs are registered. The tick on cycle N drives the new o_Anode, o_Segment, o_DP and o_Frame_Start on cycle N+1.
- Each digit dwells exactly TICKS cycles. A frame is DECIMAL_DIGITS*TICKS cycles.
- An input change coincident with the snapshot-load tick is captured. A change one cycle later waits for the next frame.
- Reset asserted mid-frame blanks the outputs immediately. Scanning restarts from digit 0 as after a fresh reset.

## Configuration
- LEADING_ZERO_BLANK_EN defined:
  - Digits from the most significant downward whose snapshot nibble is 0 drive 7'h7F, stopping at the first nonzero digit.
  - Digit 0 is never blanked. The anode still scans.
  - o_DP is unaffected.
- LEADING_ZERO_BLANK_EN undefined: every digit decodes normally, so leading zeros are shown.

## Structure
- Shared package seven_segment_pkg holds:
  - The segment constants: SEG_0..SEG_9, SEG_BLANK = 7'h7F, SEG_DASH = 7'b0111111.
  - The TICKS calculation function.
  - The DECIMAL_DIGITS default.
- Sub-module bcd_to_seven_segment is the purely combinational nibble-to-segment decoder. It is instantiated once and feeds the output register.

## Test plan
Bench parameters: CLK_FREQ_HZ=40, DIGIT_HZ=10, so TICKS=4.
- Reset: hold i_Rst_n=0, then release.
  - While low: o_Anode=4'hF, o_Segment=7'h7F, o_DP=1.
  - After release: dark for 4 cycles, then a single o_Frame_Start pulse with o_Anode=1110.
- i_Display_Time=16'h1228, PM=0: each frame shows the following, 4 cycles each, with o_DP=1 throughout:
  - Anode 1110 with 0000000.
  - Anode 1101 with 0100100.
  - Anode 1011 with 0100100.
  - Anode 0111 with 1111001.
- PM=1 with the same time: o_DP=0 exactly in the cycles when o_Anode=1110.
- Change to 16'h0516 while digit 1 is active: the rest of the frame still shows 2,1. The next frame shows 6,1,5,0.
- Invalid nibble and mid-frame reset:
  - Time 16'h00A3 shows the dash on digit 1.
  - Asserting i_Rst_n=0 during digit 2 forces all outputs off in the same cycle.
- Leading-zero blanking:
  - With LEADING_ZERO_BLANK_EN, 16'h0516 gives digit 3 = 7'h7F. 16'h0000 shows only digit 0 = 1000000.
  - Without the macro, both words show every zero.
